xor_parity_sched: RTL and testbench
===================================

XOR_PARITY_SCHED -- requirements
Module: xor_parity_sched

Interface
REQ-001 The block SHALL have parameter WORD_W, default 16, giving the word width in bits; it must be a multiple of 4 and at least 4.
REQ-002 The block SHALL have parameter N_REQ, default 4, giving the number of requesters; the value is fixed at 4.
REQ-003 Port clk SHALL be input, 1 bit, the single clock; all state changes on its rising edge.
REQ-004 Port rst_n SHALL be input, 1 bit, the reset, asynchronous and active-low.
REQ-005 Port req SHALL be input, 4 bits, per-requester request level.
REQ-006 Port data SHALL be input, 4*WORD_W bits; requester i drives slice [i*WORD_W +: WORD_W].
REQ-007 Port gnt SHALL be output, 4 bits, one-hot grant to the requester currently served.
REQ-008 Port owner SHALL be output, 2 bits, binary index of the granted requester.
REQ-009 Port busy SHALL be output, 1 bit, high whenever the state is not IDLE.
REQ-010 Port done SHALL be output, 1 bit, a one-cycle pulse marking parity as valid.
REQ-011 Port parity SHALL be output, 1 bit, the XOR of all WORD_W bits of the served word.

Function
REQ-012 The FSM SHALL have exactly the states IDLE, RUN and DONE.
REQ-013 In IDLE, at an edge where req is non-zero, the block SHALL do all of the following:
- pick the winner round-robin;
- set gnt and owner for the winner;
- latch the winner's data slice into a word register;
- clear the accumulator and the nibble counter;
- go to RUN.
REQ-014 Round-robin SHALL search from index ptr upward with wrap-around; after a grant to requester i, ptr SHALL become (i+1) mod 4.
REQ-015 In RUN, each edge SHALL XOR nibble[cnt] of the latched word through the shared 4-input XOR unit into the accumulator, then increment cnt.
REQ-016 When cnt = WORD_W/4-1, the RUN edge SHALL load parity from the final accumulator value and go to DONE.
REQ-017 With the default WORD_W the cycle-level timing SHALL be:
- gnt is high from the grant edge E0;
- nibbles 0..3 are processed at edges E1..E4;
- done = 1 and parity are valid in the cycle after E4;
- the block returns to IDLE at E5;
- the next arbitration happens at E6 at the earliest.
REQ-018 gnt and owner SHALL hold steady from E0 through the DONE cycle; gnt SHALL be 0 in IDLE.
REQ-019 parity SHALL hold its value until the next DONE or reset.
REQ-020 Changes to req or data after E0 SHALL NOT affect the job in progress.
- A requester dropping req mid-job does not abort the job.
REQ-021 If a served requester keeps req high after done, it SHALL be regranted only when round-robin reaches it again.
REQ-022 Requests arriving during RUN or DONE SHALL NOT be lost; they remain pending while req stays high and are arbitrated in the next IDLE.

Reset
REQ-023 While rst_n = 0, the block SHALL hold:
- state = IDLE;
- gnt = 0, owner = 0, busy = 0, done = 0, parity = 0;
- ptr = 0, cnt = 0, accumulator = 0, word register = 0.
REQ-024 Reset asserted mid-RUN or mid-DONE SHALL abandon the job at once; no done pulse SHALL follow.
REQ-025 After rst_n rises, the first arbitration SHALL occur at the first edge where req is non-zero.

Structure
REQ-026 Package xor_parity_sched_pkg SHALL hold:
- the state encoding (IDLE = 0, RUN = 1, DONE = 2);
- the N_REQ constant;
- the default WORD_W.
REQ-027 The 4-input XOR SHALL be one instantiated sub-module, parity4_unit, with four 1-bit inputs and a 1-bit XOR output; it is the shared resource.
REQ-028 Arbitration, FSM and accumulator SHALL live in xor_parity_sched; no further sub-modules.

Verification
REQ-029 The bench SHALL cover: req = 0001 with data0 = 16'h0001 -> gnt = 0001 at E0, done pulse in the cycle after E4, parity = 1, owner = 0.
REQ-030 The bench SHALL cover: req = 0010 with data1 = 16'hFFFF -> parity = 0, owner = 1.
REQ-031 The bench SHALL cover: req = 1111 held from reset release -> grant order 0, 1, 2, 3, 0, with each job 6 cycles apart.
REQ-032 The bench SHALL cover: data0 = 16'h0007 latched, then data0 = 16'h0000 and req dropped at E2 -> parity = 1 from the latched word.
REQ-033 The bench SHALL cover: rst_n pulled low at E3 of a job -> all outputs 0 immediately, no done pulse; req = 0100 afterwards -> gnt = 0100.
REQ-034 The bench SHALL cover: req1 and req2 held high -> grants alternate 1, 2, 1, 2.

Source files
------------

// File: rtl/xor_parity_sched_pkg.sv
// Shared constants and state encoding for the XOR parity scheduler.
package xor_parity_sched_pkg;

  localparam int N_REQ          = 4;
  localparam int WORD_W_DEFAULT = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/xor_parity_sched_parity4_unit.sv
// Shared 4-input XOR reduction; folds one nibble per cycle into the parity.
module parity4_unit (
  input  logic a,
  input  logic b,
  input  logic c,
  input  logic d,
  output logic y
);

  assign y = a ^ b ^ c ^ d;

endmodule

// File: rtl/xor_parity_sched.sv
// Round-robin arbiter over four requesters. The winner's word is latched
// and its parity is computed one nibble per cycle through a single shared
// 4-input XOR unit.
module xor_parity_sched #(
  parameter int WORD_W = xor_parity_sched_pkg::WORD_W_DEFAULT,
  parameter int N_REQ  = xor_parity_sched_pkg::N_REQ
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*WORD_W-1:0] data,
  output logic [N_REQ-1:0]        gnt,
  output logic [1:0]              owner,
  output logic                    busy,
  output logic                    done,
  output logic                    parity
);

  import xor_parity_sched_pkg::*;

  localparam int NIB   = WORD_W / 4;
  localparam int CNT_W = (NIB > 1) ? $clog2(NIB) : 1;

  state_t              state;
  logic [1:0]          ptr;
  logic [CNT_W-1:0]    cnt;
  logic                acc;
  logic [WORD_W-1:0]   word_q;

  logic [3:0]          nib;
  logic                nib_par;
  logic                win_vld;
  logic [1:0]          win;
  logic [1:0]          cand;

  // Round-robin pick: first asserted req at or after ptr, wrapping.
  // Scanning from the far end lets the nearest candidate overwrite.
  always_comb begin
    win_vld = 1'b0;
    win     = ptr;
    cand    = ptr;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      cand = ptr + 2'(k);
      if (req[cand]) begin
        win_vld = 1'b1;
        win     = cand;
      end
    end
  end

  assign nib = word_q[4*cnt +: 4];

  parity4_unit u_parity4 (
    .a (nib[0]),
    .b (nib[1]),
    .c (nib[2]),
    .d (nib[3]),
    .y (nib_par)
  );

  assign busy = (state != IDLE);

  // Control FSM: grant and latch, fold nibbles, then a one-cycle done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      gnt    <= '0;
      owner  <= '0;
      done   <= 1'b0;
      parity <= 1'b0;
      ptr    <= '0;
      cnt    <= '0;
      acc    <= 1'b0;
      word_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (win_vld) begin
            gnt    <= N_REQ'(1) << win;
            owner  <= win;
            word_q <= data[win*WORD_W +: WORD_W];
            acc    <= 1'b0;
            cnt    <= '0;
            ptr    <= win + 2'd1;
            state  <= RUN;
          end
        end
        RUN: begin
          acc <= acc ^ nib_par;
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(NIB - 1)) begin
            parity <= acc ^ nib_par;
            done   <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: begin
          // Requests seen while busy stay pending and are arbitrated in IDLE.
          done  <= 1'b0;
          gnt   <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_xor_parity_sched.sv
// Directed bench for xor_parity_sched with a done-driven scoreboard.
module tb_xor_parity_sched;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req   = '0;
  logic [63:0] data  = '0;
  logic [3:0]  gnt;
  logic [1:0]  owner;
  logic        busy;
  logic        done;
  logic        parity;

  xor_parity_sched #(.WORD_W(16), .N_REQ(4)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req),
    .data   (data),
    .gnt    (gnt),
    .owner  (owner),
    .busy   (busy),
    .done   (done),
    .parity (parity)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int owner;
    bit par;
    int at;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest expected job.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_done: got done=1 owner=%0d at cycle %0d, expected none", owner, cyc);
      end else begin
        mon_e = sb.pop_front();
        check("done_cycle",  cyc,    mon_e.at);
        check("done_owner",  owner,  mon_e.owner);
        check("done_gnt",    gnt,    1 << mon_e.owner);
        check("done_parity", parity, mon_e.par);
        check("done_busy",   busy,   1);
      end
    end
  end

  task automatic wait_to(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  // Single job issued from IDLE; req held until cycle c+hold, data cleared then if clr.
  task automatic job(input logic [3:0] r, input int own, input bit par, input int hold, input bit clr);
    int c;
    c = cyc;
    req = r;
    sb.push_back('{own, par, c + 5});
    @(negedge clk);
    check("grant_e0", gnt,   1 << own);
    check("owner_e0", owner, own);
    wait_to(c + hold);
    req = '0;
    if (clr) data = '0;
    wait_to(c + 6);
    check("idle_gnt",    gnt,    0);
    check("idle_busy",   busy,   0);
    check("parity_hold", parity, par);
  endtask

  initial begin
    int c;
    repeat (2) @(negedge clk);
    check("rst_gnt",    gnt,    0);
    check("rst_owner",  owner,  0);
    check("rst_busy",   busy,   0);
    check("rst_done",   done,   0);
    check("rst_parity", parity, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("noreq_busy", busy, 0);

    // single requester 0, odd word
    data = 64'h0000_0000_0000_0001;
    job(4'b0001, 0, 1'b1, 1, 1'b0);
    // single requester 1, all ones
    data = 64'h0000_0000_FFFF_0000;
    job(4'b0010, 1, 1'b0, 1, 1'b0);
    // latched word survives data/req change at E2 (ptr=2, wraps to 0)
    data = 64'h0000_0000_0000_0007;
    job(4'b0001, 0, 1'b1, 2, 1'b1);

    // two requesters held: alternate 1,2,1,2 (ptr=1)
    data = {16'h0000, 16'h0001, 16'hFFFF, 16'h0000};
    c = cyc;
    req = 4'b0110;
    sb.push_back('{1, 1'b0, c + 5});
    sb.push_back('{2, 1'b1, c + 11});
    sb.push_back('{1, 1'b0, c + 17});
    sb.push_back('{2, 1'b1, c + 23});
    wait_to(c + 19);
    req = '0;
    wait_to(c + 26);
    check("alt_idle", busy, 0);

    // all four held from reset release: 0,1,2,3,0 six cycles apart
    rst_n = 1'b0;
    req   = 4'b1111;
    data  = {16'h8000, 16'h1234, 16'hFFFF, 16'h0003};
    @(negedge clk);
    c = cyc;
    rst_n = 1'b1;
    sb.push_back('{0, 1'b0, c + 5});
    sb.push_back('{1, 1'b0, c + 11});
    sb.push_back('{2, 1'b1, c + 17});
    sb.push_back('{3, 1'b1, c + 23});
    sb.push_back('{0, 1'b0, c + 29});
    wait_to(c + 25);
    req = '0;
    wait_to(c + 32);

    // reset at E3 abandons the job; then requester 2 gets served
    data = 64'h0000_0000_0000_0001;
    c = cyc;
    req = 4'b0001;
    @(negedge clk);
    check("abort_gnt_e0", gnt, 4'b0001);
    req = '0;
    wait_to(c + 3);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("abort_gnt",    gnt,    0);
    check("abort_owner",  owner,  0);
    check("abort_busy",   busy,   0);
    check("abort_done",   done,   0);
    check("abort_parity", parity, 0);
    repeat (2) @(negedge clk);
    req  = 4'b0100;
    data = {16'h0000, 16'h1234, 16'h0000, 16'h0000};
    c = cyc;
    rst_n = 1'b1;
    sb.push_back('{2, 1'b1, c + 5});
    @(negedge clk);
    check("post_rst_gnt", gnt, 4'b0100);
    req = '0;
    wait_to(c + 9);

    check("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
